// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and constants for the I2C command arbiter.
package i2c_arb_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int RETRY_W    = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_CHECK = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      CHECK = ST_CHECK
   } state_e;

   // Next round-robin start position after requester 'owner' has been served.
   function automatic int rr_next(input int owner, input int n);
      return (n <= 1) ? 0 : (owner + 1) % n;
   endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and engine signals of the I2C command arbiter.
// master: the arbiter side; slave: requesters plus the write engine.
interface i2c_arb_if
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = DATA_W_DEF
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_done;
   logic                      rsp_err;
   logic                      busy;
   logic [DATA_W-1:0]         i2c_data;
   logic                      i2c_go;
   logic                      i2c_end;
   logic                      i2c_ack;

   modport master (
      input  req_valid, req_data, i2c_end, i2c_ack,
      output req_ready, rsp_done, rsp_err, busy, i2c_data, i2c_go
   );

   modport slave (
      output req_valid, req_data, i2c_end, i2c_ack,
      input  req_ready, rsp_done, rsp_err, busy, i2c_data, i2c_go
   );

endinterface

// File: rtl/i2c_cmd_arbiter_rr.sv
// Combinational round-robin picker: first active request at or after the
// pointer, wrapping to index 0.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   gnt_idx_o,
   output logic               gnt_any_o
);

   // Upper segment (>= ptr) first, then the wrapped lower segment.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any_o && req_i[i] && (i >= int'(ptr_i))) begin
            gnt_any_o = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = PTR_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any_o && req_i[i] && (i < int'(ptr_i))) begin
            gnt_any_o = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one 24-bit I2C write engine between NUM_REQ requesters with
// round-robin grant, NACK retry and per-requester completion reporting.
// Optional per-transaction timeout: define I2C_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; grant next requester from rr pointer
// ISSUE | i2c_go high, waiting for engine to pull i2c_end low
// WAIT  | transfer running, waiting for i2c_end high
// CHECK | i2c_go low; finish, or reissue the same command after a NACK
module i2c_cmd_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_RETRY   = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic      sys_clk,
   input  logic      sys_rst_n,
   i2c_arb_if.master bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if ((NUM_REQ < 1) || (NUM_REQ > 4)) begin : g_bad_num_req
      $error("i2c_cmd_arbiter: NUM_REQ must be 1..4");
   end
   if ((MAX_RETRY < 0) || (MAX_RETRY > 7)) begin : g_bad_retry
      $error("i2c_cmd_arbiter: MAX_RETRY must be 0..7");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("i2c_cmd_arbiter: TIMEOUT_CYC must be >= 1");
   end

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 go_q, go_d;
   logic                 ack_q, ack_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [PTR_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic                 finish;
   logic                 fin_err;
   logic [NUM_REQ-1:0]   done_vec;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_i     (bus.req_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;

   // Terminal count reached while the engine holds the bus.
   assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) && (tmo_q == '0);

   // Down-counter loaded at grant; it keeps running across retries so the
   // budget covers the whole transaction, and holds during CHECK.
   always_comb begin
      tmo_d = tmo_q;
      if ((state_q == IDLE) && gnt_any) begin
         tmo_d = TMO_W'(TIMEOUT_CYC - 1);
      end else if (((state_q == ISSUE) || (state_q == WAIT)) && (tmo_q != '0)) begin
         tmo_d = tmo_q - TMO_W'(1);
      end
   end

   // Timeout counter register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   // Next-state logic for the grant / issue / wait / check sequence.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      retry_d = retry_q;
      data_d  = data_q;
      go_d    = go_q;
      ack_d   = ack_q;
      ready_d = '0;
      finish  = 1'b0;
      fin_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (gnt[i]) begin
                     data_d = bus.req_data[i*DATA_W +: DATA_W];
                  end
               end
               ready_d = gnt;
               owner_d = gnt_idx;
               retry_d = '0;
               go_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.i2c_end) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.i2c_end) begin
               go_d    = 1'b0;
               ack_d   = bus.i2c_ack;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (ack_q && (int'(retry_q) < MAX_RETRY)) begin
               retry_d = retry_q + RETRY_W'(1);
               go_d    = 1'b1;
               state_d = ISSUE;
            end else begin
               finish  = 1'b1;
               fin_err = ack_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef I2C_ARB_TIMEOUT_EN
      if (tmo_hit) begin
         finish  = 1'b1;
         fin_err = 1'b1;
         go_d    = 1'b0;
      end
`endif
      if (finish) begin
         ptr_d   = PTR_W'(rr_next(int'(owner_q), NUM_REQ));
         retry_d = '0;
         state_d = IDLE;
      end
   end

   // State and datapath registers; async reset drops i2c_go immediately.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         retry_q <= '0;
         data_q  <= '0;
         go_q    <= 1'b0;
         ack_q   <= 1'b0;
         ready_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         retry_q <= retry_d;
         data_q  <= data_d;
         go_q    <= go_d;
         ack_q   <= ack_d;
         ready_q <= ready_d;
      end
   end

   // Completion pulse goes to the current owner only.
   always_comb begin
      done_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         done_vec[i] = finish && (int'(owner_q) == i);
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_done  = done_vec;
   assign bus.rsp_err   = finish & fin_err;
   assign bus.busy      = (state_q != IDLE);
   assign bus.i2c_data  = data_q;
   assign bus.i2c_go    = go_q;

endmodule
